mont_ladder_exp: RTL and testbench

- Parametrised modular exponentiator: computes result = x^e mod m with a Montgomery-ladder schedule.
- Built around an internal bit-serial radix-2 Montgomery multiplier.
- Successor to the fixed-1024-bit ladder: width and exponent-length counter are generic, and it adds busy/err status, lene clamping and an optional dual-multiplier mode.
- Sits under the top-level RSA controller, which supplies precomputed r = 2^WIDTH mod m and r2 = 2^(2*WIDTH) mod m.

---
 rtl/mont_ladder_exp.sv | 253 +++++++++++++++++++++++++
 tb/tb_mont_ladder_exp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_ladder_exp.sv
// mont_ladder_exp: result = x^e mod m, Montgomery ladder over a bit-serial MM.
// Define LADDER_DUAL_MM_EN to run both per-bit ladder products concurrently.

module mont_ladder_mm #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             fin,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH + 2);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH+1:0] t_q, t_d, s1, mw;

  // cnt 0 loads, 1..WIDTH iterate, WIDTH+1 is the subtract/hand-off cycle
  always_comb begin
    mw    = {2'b00, m};
    s1    = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    fin   = run && (cnt_q == CW'(WIDTH + 1));
    res   = (t_q >= mw) ? t_q[WIDTH-1:0] - m : t_q[WIDTH-1:0];
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    t_d   = t_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      a_d   = a;
      b_d   = b;
      t_d   = '0;
      cnt_d = CW'(1);
    end else if (fin) begin
      cnt_d = '0;
    end else begin
      t_d   = (s1 + (s1[0] ? mw : '0)) >> 1;
      a_d   = a_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    t_q <= t_d;
  end
endmodule

module mont_ladder_exp #(
  parameter int WIDTH = 1024,
  parameter int LENW  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  input  logic [LENW-1:0]  lene,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = (LENW > BW) ? LENW : BW;

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_LOOP, S_FROMMONT, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, e_q, e_d, r2_q, r2_d;
  logic [WIDTH-1:0] acc_a_q, acc_a_d, acc_x_q, acc_x_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    bit_q, bit_d, len_eff;
  logic [CW-1:0]    lene_w;
  logic             done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic             ebit, run;
  logic [WIDTH-1:0] op0_a, op0_b, res0;
  logic             fin0;
`ifdef LADDER_DUAL_MM_EN
  logic [WIDTH-1:0] op1_a, op1_b, res1;
  logic             fin1;
`else
  logic             ph_q, ph_d;
`endif

  mont_ladder_mm #(.WIDTH(WIDTH)) u_mm0 (
    .clk(clk), .resetn(resetn), .run(run),
    .a(op0_a), .b(op0_b), .m(m_q),
    .fin(fin0), .res(res0)
  );

`ifdef LADDER_DUAL_MM_EN
  mont_ladder_mm #(.WIDTH(WIDTH)) u_mm1 (
    .clk(clk), .resetn(resetn), .run(run),
    .a(op1_a), .b(op1_b), .m(m_q),
    .fin(fin1), .res(res1)
  );
`endif

  always_comb begin
    lene_w  = CW'(lene);
    len_eff = (lene_w > CW'(WIDTH)) ? BW'(WIDTH) : BW'(lene_w);
    ebit    = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (bit_q == BW'(i + 1)) ebit = e_q[i];

    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    r2_d     = r2_q;
    acc_a_d  = acc_a_q;
    acc_x_d  = acc_x_q;
    bit_d    = bit_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    run      = 1'b0;
    op0_a    = acc_a_q;
    op0_b    = acc_x_q;
`ifdef LADDER_DUAL_MM_EN
    op1_a    = ebit ? acc_x_q : acc_a_q;
    op1_b    = ebit ? acc_x_q : acc_a_q;
`else
    ph_d     = ph_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          m_d      = in_m;
          e_d      = in_e;
          r2_d     = in_r2;
          acc_a_d  = in_r;
          acc_x_d  = in_x;
          bit_d    = len_eff;
          result_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
`ifndef LADDER_DUAL_MM_EN
          ph_d     = 1'b0;
`endif
          state_d  = in_m[0] ? S_TOMONT : S_ERR;
        end
      end
      S_TOMONT: begin
        run   = 1'b1;
        op0_a = acc_x_q;
        op0_b = r2_q;
        if (fin0) begin
          acc_x_d = res0;
          state_d = (bit_q == '0) ? S_FROMMONT : S_LOOP;
        end
      end
      S_LOOP: begin
        run = 1'b1;
`ifdef LADDER_DUAL_MM_EN
        if (fin0 && fin1) begin
          acc_a_d = ebit ? res0 : res1;
          acc_x_d = ebit ? res1 : res0;
          bit_d   = bit_q - BW'(1);
          if (bit_q == BW'(1)) state_d = S_FROMMONT;
        end
`else
        // second product squares whichever register the bit did not update
        if (ph_q) begin
          op0_a = ebit ? acc_x_q : acc_a_q;
          op0_b = ebit ? acc_x_q : acc_a_q;
        end
        if (fin0) begin
          if (ebit ^ ph_q) acc_a_d = res0;
          else             acc_x_d = res0;
          ph_d = ~ph_q;
          if (ph_q) begin
            bit_d = bit_q - BW'(1);
            if (bit_q == BW'(1)) state_d = S_FROMMONT;
          end
        end
`endif
      end
      S_FROMMONT: begin
        run   = 1'b1;
        op0_a = acc_a_q;
        op0_b = WIDTH'(1);
        if (fin0) begin
          result_d = res0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_d   = 1'b1;
        err_d    = 1'b1;
        result_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    m_q     <= m_d;
    e_q     <= e_d;
    r2_q    <= r2_d;
    acc_a_q <= acc_a_d;
    acc_x_q <= acc_x_d;
    bit_q   <= bit_d;
`ifndef LADDER_DUAL_MM_EN
    ph_q    <= ph_d;
`endif
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign err    = err_q;
endmodule

// File: tb/tb_mont_ladder_exp.sv
// tb_mont_ladder_exp: table/scoreboard bench, 8-bit instance for corner cases
// plus one 1024-bit instance checked against a square-and-multiply model.

module tb_mont_ladder_exp;
  localparam int W8 = 8;
  localparam int M8 = W8 + 2;
  localparam int WB = 1024;
  localparam int MB = WB + 2;
  localparam int LB = 16;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0 = 0;

  logic          start8;
  logic [W8-1:0] x8, m8, e8, r8, r28, res8;
  logic [31:0]   lene8;
  logic          done8, busy8, err8;

  logic          startb;
  logic [WB-1:0] xb, mb, eb, rb, r2b, resb, expb;
  logic [31:0]   leneb;
  logic          doneb, busyb, errb;

  mont_ladder_exp #(.WIDTH(W8), .LENW(32)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8),
    .in_x(x8), .in_m(m8), .in_e(e8), .in_r(r8), .in_r2(r28),
    .lene(lene8), .result(res8), .done(done8), .busy(busy8), .err(err8)
  );

  mont_ladder_exp #(.WIDTH(WB), .LENW(32)) dutb (
    .clk(clk), .resetn(resetn), .start(startb),
    .in_x(xb), .in_m(mb), .in_e(eb), .in_r(rb), .in_r2(r2b),
    .lene(leneb), .result(resb), .done(doneb), .busy(busyb), .err(errb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  x, m, e, r, r2;
    logic [31:0] lene;
    logic [7:0]  res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         lat;
  } exp_t;

  vec_t tbl[NV];
  exp_t sb[$];

  function automatic vec_t mkv(input logic [7:0] x, m, e, r, r2,
                               input logic [31:0] lene,
                               input logic [7:0] res, input logic err);
    vec_t v;
    v.x = x; v.m = m; v.e = e; v.r = r; v.r2 = r2;
    v.lene = lene; v.res = res; v.err = err;
    return v;
  endfunction

  function automatic int lat8(input logic [31:0] lene, input logic err);
    int l;
    if (err) return 1;
    l = (lene > 32'd8) ? 8 : int'(lene);
`ifdef LADDER_DUAL_MM_EN
    return 1 + M8 * (2 + l);
`else
    return 1 + M8 * (2 + 2 * l);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic go8(input vec_t v, input bit push);
    @(negedge clk);
    x8 = v.x; m8 = v.m; e8 = v.e; r8 = v.r; r28 = v.r2;
    lene8 = v.lene; start8 = 1'b1;
    if (push) sb.push_back('{res: v.res, err: v.err, lat: lat8(v.lene, v.err)});
    @(negedge clk);
    start8 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait8(input string name, input int budget);
    exp_t ex;
    int   n;
    int   drop;
    n = 0;
    drop = 0;
    while (!done8 && n < budget) begin
      if (!busy8) drop++;
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done in %0d cycles, expected done", name, budget);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    ex = sb.pop_front();
    chk({name, " result"}, 64'(res8), 64'(ex.res));
    chk({name, " err"}, 64'(err8), 64'(ex.err));
    chk({name, " latency"}, 64'(cyc - t0), 64'(ex.lat));
    chk({name, " busy gaps"}, 64'(drop), 64'd0);
    chk({name, " busy at done"}, 64'(busy8), 64'd1);
    @(negedge clk);
    chk({name, " done width"}, 64'(done8), 64'd0);
    chk({name, " busy after"}, 64'(busy8), 64'd0);
    chk({name, " err hold"}, 64'(err8), 64'(ex.err));
  endtask

  function automatic logic [WB-1:0] mulmod(input logic [WB-1:0] a, b, m);
    logic [WB:0] acc;
    acc = '0;
    for (int i = WB - 1; i >= 0; i--) begin
      acc = acc << 1;
      if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
      if (b[i]) acc = acc + {1'b0, a};
      if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
    end
    return acc[WB-1:0];
  endfunction

  initial begin : main
    int n;
    int cnt;
    logic [WB:0] t;

    tbl[0]  = mkv(8'd5,  8'd13,  8'h03, 8'd9, 8'd3,  32'd2,  8'd8,   1'b0);
    tbl[1]  = mkv(8'd2,  8'd13,  8'hEB, 8'd9, 8'd3,  32'd8,  8'd11,  1'b0);
    tbl[2]  = mkv(8'd5,  8'd13,  8'h03, 8'd9, 8'd3,  32'd8,  8'd8,   1'b0);
    tbl[3]  = mkv(8'd5,  8'd13,  8'h03, 8'd9, 8'd3,  32'd0,  8'd1,   1'b0);
    tbl[4]  = mkv(8'd0,  8'd13,  8'h05, 8'd9, 8'd3,  32'd3,  8'd0,   1'b0);
    tbl[5]  = mkv(8'd12, 8'd13,  8'h03, 8'd9, 8'd3,  32'd2,  8'd12,  1'b0);
    tbl[6]  = mkv(8'd2,  8'd13,  8'h81, 8'd9, 8'd3,  32'hFFFF_FFFF, 8'd5, 1'b0);
    tbl[7]  = mkv(8'd3,  8'd251, 8'hFF, 8'd5, 8'd25, 32'd8,  8'd243, 1'b0);
    tbl[8]  = mkv(8'd3,  8'd251, 8'hF5, 8'd5, 8'd25, 32'd4,  8'd243, 1'b0);
    tbl[9]  = mkv(8'd0,  8'd1,   8'h05, 8'd0, 8'd0,  32'd3,  8'd0,   1'b0);
    tbl[10] = mkv(8'd7,  8'd12,  8'h05, 8'd0, 8'd0,  32'd8,  8'd0,   1'b1);

    resetn = 1'b0;
    start8 = 1'b0; x8 = '0; m8 = '0; e8 = '0; r8 = '0; r28 = '0; lene8 = '0;
    startb = 1'b0; xb = '0; mb = '0; eb = '0; rb = '0; r2b = '0; leneb = '0;
    repeat (3) @(negedge clk);
    chk("reset result8", 64'(res8), 64'd0);
    chk("reset done8", 64'(done8), 64'd0);
    chk("reset busy8", 64'(busy8), 64'd0);
    chk("reset err8", 64'(err8), 64'd0);
    chk("reset resultb", 64'(|resb), 64'd0);
    chk("reset doneb", 64'(doneb), 64'd0);
    chk("reset busyb", 64'(busyb), 64'd0);
    chk("reset errb", 64'(errb), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      go8(tbl[i], 1'b1);
      wait8($sformatf("vec%0d", i), 400);
    end

    // the previous vector left err set; an accepted start clears it
    go8(tbl[0], 1'b1);
    chk("err cleared by start", 64'(err8), 64'd0);
    wait8("after err", 400);

    // start / input changes while busy are ignored
    go8(tbl[0], 1'b1);
    repeat (10) @(negedge clk);
    x8 = 8'd7; e8 = 8'hFF; m8 = 8'd12; lene8 = 32'd8; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    e8 = 8'h00;
    wait8("busy restart", 400);

    // reset mid-run abandons the computation
    go8(tbl[1], 1'b0);
    repeat (30) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst result", 64'(res8), 64'd0);
    chk("midrst done", 64'(done8), 64'd0);
    chk("midrst busy", 64'(busy8), 64'd0);
    chk("midrst err", 64'(err8), 64'd0);
    resetn = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done8 || busy8) cnt++;
    end
    chk("midrst no done", 64'(cnt), 64'd0);
    go8(tbl[1], 1'b1);
    wait8("after midrst", 400);

    // wide instance against a square-and-multiply reference
    for (int k = 0; k < WB / 32; k++) begin
      mb[k*32 +: 32] = $urandom;
      xb[k*32 +: 32] = $urandom;
      eb[k*32 +: 32] = $urandom;
    end
    mb[WB-1] = 1'b1;
    mb[0] = 1'b1;
    xb[WB-1] = 1'b0;
    t = 1;
    repeat (WB) begin
      t = t << 1;
      if (t >= {1'b0, mb}) t = t - {1'b0, mb};
    end
    rb = t[WB-1:0];
    r2b = mulmod(rb, rb, mb);
    expb = 1;
    for (int i = LB - 1; i >= 0; i--) begin
      expb = mulmod(expb, expb, mb);
      if (eb[i]) expb = mulmod(expb, xb, mb);
    end
    leneb = 32'(LB);
    @(negedge clk);
    startb = 1'b1;
    @(negedge clk);
    startb = 1'b0;
    t0 = cyc;
    n = 0;
    while (!doneb && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (!doneb) begin
      checks++;
      errors++;
      $display("FAIL wide timeout: got no done, expected done");
    end else begin
      checks++;
      if (resb !== expb) begin
        errors++;
        $display("FAIL wide result: got low64 %0h, expected low64 %0h",
                 resb[63:0], expb[63:0]);
      end
      chk("wide err", 64'(errb), 64'd0);
`ifdef LADDER_DUAL_MM_EN
      chk("wide latency", 64'(cyc - t0), 64'(1 + MB * (2 + LB)));
`else
      chk("wide latency", 64'(cyc - t0), 64'(1 + MB * (2 + 2 * LB)));
`endif
      @(negedge clk);
      chk("wide done width", 64'(doneb), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
